// File: rtl/bcd_adder_seq_pkg.sv
// Shared constants and state encoding for the digit-serial BCD adder.
package bcd_adder_seq_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hA;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit decimal adder: x + y + ci with decimal correction and an invalid-digit flag.
module bcd_digit_add
    import bcd_adder_seq_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] d,
    output logic       co,
    output logic       bad
);

    logic [4:0] s;

    always_comb begin
        s   = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        co  = (s > {1'b0, BCD_MAX});
        // Adding 6 modulo 16 skips the six unused codes and yields the decimal digit.
        d   = co ? (s[3:0] + 4'd6) : s[3:0];
        bad = (x > BCD_MAX) || (y > BCD_MAX);
    end

endmodule

// File: rtl/bcd_adder_seq.sv
// N-digit BCD adder processing one digit per clock, LSD first, with start/done handshake.
module bcd_adder_seq
    import bcd_adder_seq_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  error
);

    typedef logic [DIGITS-1:0][3:0] digits_t;

    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] idx_q,   idx_d;
    digits_t       a_q,     a_d;
    digits_t       b_q,     b_d;
    digits_t       sum_q,   sum_d;
    logic          c_q,     c_d;
    logic          cout_q,  cout_d;
    logic          err_q,   err_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic [3:0]    dig;
    logic          dig_co;
    logic          dig_bad;

    // Single digit adder shared by all positions through the index mux.
    bcd_digit_add u_digit (
        .x   (a_q[idx_q]),
        .y   (b_q[idx_q]),
        .ci  (c_q),
        .d   (dig),
        .co  (dig_co),
        .bad (dig_bad)
    );

    always_comb begin
        // NOTE: every next-state signal defaults to its hold value first so no path infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    sum_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d[idx_q] = dig;
                c_d          = dig_co;
                err_d        = err_q | dig_bad;
                idx_d        = idx_q + CW'(1);
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (err_q || dig_bad) begin
                        // Blank code on every digit makes the downstream 7-segment displays go dark.
                        sum_d  = {DIGITS{BCD_BLANK}};
                        cout_d = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        cout_d = dig_co;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign error = err_q;

endmodule

// File: tb/tb_bcd_adder_seq.sv
// Self-checking bench for bcd_adder_seq: 4-digit and 1-digit instances, vectors, corners, random vs decimal model.
module tb_bcd_adder_seq;

    localparam int TMO = 20;

    logic        clk;
    logic        rst_n;

    logic        start4, cin4, busy4, done4, cout4, error4;
    logic [15:0] a4, b4, sum4;

    logic        start1, cin1, busy1, done1, cout1, error1;
    logic [3:0]  a1, b1, sum1;

    int total;
    int bad;

    bcd_adder_seq #(.DIGITS(4)) u_dut4 (
        .Clock (clk),   .Resetn (rst_n), .start (start4),
        .a     (a4),    .b      (b4),    .cin   (cin4),
        .busy  (busy4), .done   (done4), .sum   (sum4),
        .cout  (cout4), .error  (error4)
    );

    bcd_adder_seq #(.DIGITS(1)) u_dut1 (
        .Clock (clk),   .Resetn (rst_n), .start (start1),
        .a     (a1),    .b      (b1),    .cin   (cin1),
        .busy  (busy1), .done   (done1), .sum   (sum1),
        .cout  (cout1), .error  (error1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: operands are turned into integers, added, and converted back.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic c,
                                  input int nd, output logic [63:0] s, output logic co,
                                  output logic er);
        longint va, vb, p, tot;
        logic [3:0] da, db;
        va = 0; vb = 0; p = 1; er = 1'b0; s = '0; co = 1'b0;
        for (int i = 0; i < nd; i++) begin
            da = a[4*i +: 4];
            db = b[4*i +: 4];
            if (da > 9 || db > 9) er = 1'b1;
            va += longint'(da) * p;
            vb += longint'(db) * p;
            p  *= 10;
        end
        if (er) begin
            for (int i = 0; i < nd; i++) s[4*i +: 4] = 4'hA;
        end else begin
            tot = va + vb + longint'(c);
            co  = (tot >= p);
            tot = tot % p;
            for (int i = 0; i < nd; i++) begin
                s[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end
    endfunction

    function automatic logic [15:0] rand_bcd(input int nd);
        logic [15:0] v;
        int r;
        v = '0;
        for (int i = 0; i < nd; i++) begin
            r = int'($urandom_range(0, 15));
            v[4*i +: 4] = (r < 14) ? 4'(r % 10) : 4'(10 + $urandom_range(0, 5));
        end
        return v;
    endfunction

    task automatic wait_done4(output int lat, output int bcyc);
        lat = 0; bcyc = 0;
        while (!done4 && lat < TMO) begin
            bcyc += int'(busy4);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output int lat, output int bcyc);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(lat, bcyc);
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic c, output int lat);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        int          lat, bcyc, cnt;
        logic [63:0] es;
        logic        ec, ee;
        logic [15:0] ra, rb;
        logic        rc;

        total = 0; bad = 0;
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[3] = '{16'h12A4, 16'h0001, 1'b0, 16'hAAAA, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[5] = '{16'h0050, 16'h0050, 1'b0, 16'h0100, 1'b0, 1'b0};

        #12;
        check("rst busy4",  64'(busy4),  0);
        check("rst done4",  64'(done4),  0);
        check("rst sum4",   64'(sum4),   0);
        check("rst cout4",  64'(cout4),  0);
        check("rst error4", 64'(error4), 0);
        check("rst sum1",   64'(sum1),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcyc);
            check($sformatf("vec%0d latency", i), 64'(lat),    4);
            check($sformatf("vec%0d busy",    i), 64'(bcyc),   4);
            check($sformatf("vec%0d sum",     i), 64'(sum4),   64'(vecs[i].sum));
            check($sformatf("vec%0d cout",    i), 64'(cout4),  64'(vecs[i].cout));
            check($sformatf("vec%0d error",   i), 64'(error4), 64'(vecs[i].err));
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), 64'(done4), 0);
            check($sformatf("vec%0d sum held",   i), 64'(sum4),  64'(vecs[i].sum));
        end

        // A start pulse two cycles into an operation must be ignored.
        @(negedge clk);
        a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a4 = 16'h7777; b4 = 16'h1111; cin4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(lat, bcyc);
        check("ignore latency", 64'(lat),  1);
        check("ignore sum",     64'(sum4), 64'h3333);
        check("ignore cout",    64'(cout4), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(done4) + int'(busy4);
        end
        check("ignore no extra op", 64'(cnt), 0);

        // Start asserted in the done cycle is accepted.
        run4(16'h0002, 16'h0003, 1'b0, lat, bcyc);
        check("b2b first sum", 64'(sum4), 64'h0005);
        a4 = 16'h0004; b4 = 16'h0005; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("b2b busy",  64'(busy4), 1);
        check("b2b done low", 64'(done4), 0);
        wait_done4(lat, bcyc);
        check("b2b latency", 64'(lat),  4);
        check("b2b sum",     64'(sum4), 64'h0009);

        // Asynchronous reset in the middle of ADD.
        @(negedge clk);
        a4 = 16'h1234; b4 = 16'h1111; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst busy",  64'(busy4),  0);
        check("mid rst done",  64'(done4),  0);
        check("mid rst sum",   64'(sum4),   0);
        check("mid rst cout",  64'(cout4),  0);
        check("mid rst error", 64'(error4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt += int'(done4);
        end
        check("mid rst no done", 64'(cnt), 0);
        run4(16'h0050, 16'h0050, 1'b0, lat, bcyc);
        check("post rst sum",  64'(sum4),  64'h0100);
        check("post rst cout", 64'(cout4), 0);

        // Randomized 4-digit operations against the decimal model.
        for (int i = 0; i < 30; i++) begin
            ra = rand_bcd(4);
            rb = rand_bcd(4);
            rc = 1'($urandom_range(0, 1));
            model(64'(ra), 64'(rb), rc, 4, es, ec, ee);
            run4(ra, rb, rc, lat, bcyc);
            check($sformatf("rnd%0d latency", i), 64'(lat),    4);
            check($sformatf("rnd%0d sum %h+%h+%0d", i, ra, rb, rc), 64'(sum4), es);
            check($sformatf("rnd%0d cout", i),    64'(cout4),  64'(ec));
            check($sformatf("rnd%0d error", i),   64'(error4), 64'(ee));
        end

        // Single-digit instance.
        run1(4'd9, 4'd9, 1'b1, lat);
        check("d1 latency", 64'(lat),   1);
        check("d1 999 sum", 64'(sum1),  9);
        check("d1 999 cout", 64'(cout1), 1);
        run1(4'd4, 4'd5, 1'b0, lat);
        check("d1 45 sum",  64'(sum1),  9);
        check("d1 45 cout", 64'(cout1), 0);
        for (int i = 0; i < 12; i++) begin
            ra = rand_bcd(1);
            rb = rand_bcd(1);
            rc = 1'($urandom_range(0, 1));
            model(64'(ra), 64'(rb), rc, 1, es, ec, ee);
            run1(ra[3:0], rb[3:0], rc, lat);
            check($sformatf("d1 rnd%0d latency", i), 64'(lat), 1);
            check($sformatf("d1 rnd%0d sum %h+%h+%0d", i, ra[3:0], rb[3:0], rc), 64'(sum1), es);
            check($sformatf("d1 rnd%0d cout", i),  64'(cout1),  64'(ec));
            check($sformatf("d1 rnd%0d error", i), 64'(error1), 64'(ee));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
